// File: rtl/branch_resolve_bht_if.sv
// Branch resolution bus between the fetch/decode pipeline and branch_resolve_bht.
//
// Signals:
//   pcF          fetch PC, indexes the BHT
//   pred_takenF  fetch-stage prediction for pcF
//   stallD       holds the fetch-to-decode prediction register, blocks resolution
//   flushD       clears the fetch-to-decode prediction register
//   validD       decode-stage instruction is valid
//   opD, rtD     decode-stage opcode and rt field
//   aD, bD       forwarded rs / rt operand values
//   branchD      decode is a conditional branch
//   takenD       resolved branch outcome
//   mispredictD  valid branch whose outcome differs from its fetch prediction
//   branch_cnt   saturating count of resolved branches
//   mispred_cnt  saturating count of mispredictions
//
// master: pipeline side (drives PC/decode/operands); slave: the resolution unit.
interface branch_resolve_bht_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [31:0]       pcF;
  logic              pred_takenF;
  logic              stallD;
  logic              flushD;
  logic              validD;
  logic [5:0]        opD;
  logic [4:0]        rtD;
  logic [DATA_W-1:0] aD;
  logic [DATA_W-1:0] bD;
  logic              branchD;
  logic              takenD;
  logic              mispredictD;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output pcF, stallD, flushD, validD, opD, rtD, aD, bD,
    input  pred_takenF, branchD, takenD, mispredictD, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pcF, stallD, flushD, validD, opD, rtD, aD, bD,
    output pred_takenF, branchD, takenD, mispredictD, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Decode-stage branch resolution for the five-stage MIPS pipeline with a
// 2-bit saturating branch-history table (BHT).
//
// The BHT is read combinationally in fetch (pcF[IDX_W+1:2]); the prediction
// and its index travel to decode in a small register, and the entry is
// trained when the branch resolves in decode. Mispredictions are flagged to
// the hazard unit, and two saturating performance counters track resolved
// branches and mispredictions.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     branch_resolve_bht_if.slave (fetch PC, decode fields, operands,
//           prediction/resolution outputs and counters)
module branch_resolve_bht #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  branch_resolve_bht_if.slave  bus
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam int unsigned DEPTH_U = BHT_DEPTH;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  ctr_t             bht [DEPTH_U];

  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxD;
  logic             predD;

  logic             branch;
  logic             taken;
  logic             mispredict;
  logic             resolve;

  logic             a_neg;
  logic             a_zero;
  logic             ab_eq;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Saturating 2-bit counter step.
  function automatic ctr_t ctr_step(input ctr_t c, input logic up);
    ctr_t n;
    n = c;
    if (up) begin
      unique case (c)
        CTR_SNT: n = CTR_WNT;
        CTR_WNT: n = CTR_WT;
        CTR_WT:  n = CTR_ST;
        CTR_ST:  n = CTR_ST;
      endcase
    end else begin
      unique case (c)
        CTR_SNT: n = CTR_SNT;
        CTR_WNT: n = CTR_SNT;
        CTR_WT:  n = CTR_WNT;
        CTR_ST:  n = CTR_WT;
      endcase
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Fetch-side lookup. Reads the array as it stands before this edge's write,
  // so a same-index update is not bypassed.
  // ---------------------------------------------------------------------------
  assign idxF = bus.pcF[IDX_W+1:2];

  always_comb begin
    bus.pred_takenF = bht[idxF][1];
  end

  // ---------------------------------------------------------------------------
  // Decode-stage compare and opcode decode.
  // ---------------------------------------------------------------------------
  assign a_neg  = bus.aD[DATA_W-1];
  assign a_zero = (bus.aD == '0);
  assign ab_eq  = (bus.aD == bus.bD);

  always_comb begin
    branch = 1'b0;
    taken  = 1'b0;
    case (bus.opD)
      OP_BEQ: begin
        branch = 1'b1;
        taken  = ab_eq;
      end
      OP_BNE: begin
        branch = 1'b1;
        taken  = !ab_eq;
      end
      OP_BLEZ: begin
        branch = 1'b1;
        taken  = a_neg || a_zero;
      end
      OP_BGTZ: begin
        branch = 1'b1;
        taken  = !a_neg && !a_zero;
      end
      OP_REGIMM: begin
        case (bus.rtD)
          RT_BGEZ, RT_BGEZAL: begin
            branch = 1'b1;
            taken  = !a_neg;
          end
          RT_BLTZ, RT_BLTZAL: begin
            branch = 1'b1;
            taken  = a_neg;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mispredict = bus.validD && branch && (taken != predD);
  // A stalled branch is re-presented next cycle, so it only trains once.
  assign resolve    = bus.validD && branch && !bus.stallD;

  assign bus.branchD     = branch;
  assign bus.takenD      = taken;
  assign bus.mispredictD = mispredict;

  // ---------------------------------------------------------------------------
  // Fetch-to-decode prediction register. Flush wins over the load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      predD <= 1'b0;
      idxD  <= '0;
    end else if (bus.flushD) begin
      predD <= 1'b0;
      idxD  <= '0;
    end else if (!bus.stallD) begin
      predD <= bus.pred_takenF;
      idxD  <= idxF;
    end
  end

  // ---------------------------------------------------------------------------
  // BHT training at resolution. Reset leaves every entry weakly not-taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        bht[i] <= CTR_WNT;
      end
    end else if (resolve) begin
      bht[idxD] <= ctr_step(bht[idxD], taken);
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (resolve) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (DATA_W=32, BHT_DEPTH=64, CNT_W=4).
module tb_branch_resolve_bht;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic clk;
  logic resetn;

  int n_chk  = 0;
  int n_fail = 0;

  branch_resolve_bht_if #(.DATA_W(32), .CNT_W(4)) bus ();

  branch_resolve_bht #(
    .DATA_W   (32),
    .BHT_DEPTH(64),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b);
    bus.validD = v;
    bus.opD    = op;
    bus.rtD    = rt;
    bus.aD     = a;
    bus.bD     = b;
  endtask

  task automatic chk_cnt(input string tag, input int eb, input int em);
    chk({tag, "_bcnt"}, 32'(bus.branch_cnt), 32'(eb));
    chk({tag, "_mcnt"}, 32'(bus.mispred_cnt), 32'(em));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.stallD = 1'b0;
    bus.flushD = 1'b0;
    drive(1'b0, OP_R, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic        eb;
    logic        et;
  } vec_t;

  vec_t vecs [16] = '{
    '{OP_BEQ,    5'b00000, 32'd5,          32'd5, 1'b1, 1'b1},
    '{OP_BEQ,    5'b00000, 32'd5,          32'd6, 1'b1, 1'b0},
    '{OP_BNE,    5'b00000, 32'd3,          32'd4, 1'b1, 1'b1},
    '{OP_BNE,    5'b00000, 32'd3,          32'd3, 1'b1, 1'b0},
    '{OP_BLEZ,   5'b00000, 32'd0,          32'd9, 1'b1, 1'b1},
    '{OP_BLEZ,   5'b00000, 32'd1,          32'd0, 1'b1, 1'b0},
    '{OP_BLEZ,   5'b00000, 32'h8000_0000,  32'd0, 1'b1, 1'b1},
    '{OP_BGTZ,   5'b00000, 32'h8000_0000,  32'd0, 1'b1, 1'b0},
    '{OP_BGTZ,   5'b00000, 32'd0,          32'd0, 1'b1, 1'b0},
    '{OP_BGTZ,   5'b00000, 32'd1,          32'd0, 1'b1, 1'b1},
    '{OP_REGIMM, 5'b10001, 32'd0,          32'd0, 1'b1, 1'b1},
    '{OP_REGIMM, 5'b00000, 32'hFFFF_FFFF,  32'd0, 1'b1, 1'b1},
    '{OP_REGIMM, 5'b00001, 32'hFFFF_FFFF,  32'd0, 1'b1, 1'b0},
    '{OP_REGIMM, 5'b10000, 32'h8000_0000,  32'd0, 1'b1, 1'b1},
    '{OP_REGIMM, 5'b00010, 32'd0,          32'd0, 1'b0, 1'b0},
    '{OP_R,      5'b00000, 32'd5,          32'd5, 1'b0, 1'b0}
  };

  initial begin
    resetn     = 1'bx;
    bus.pcF    = 32'h0;
    bus.stallD = 1'b0;
    bus.flushD = 1'b0;
    drive(1'b0, OP_R, 5'd0, 32'd0, 32'd0);
    #0;
    resetn = 1'b0;
    #1;
    chk("rst_pred", 32'(bus.pred_takenF), 32'd0);
    chk_cnt("rst", 0, 0);
    do_reset();

    // ---- BEQ resolved twice at pc 0x104 (index 1) ----
    bus.pcF = 32'h104;
    #1 chk("beq_c0_pred", 32'(bus.pred_takenF), 32'd0);
    tick();
    drive(1'b1, OP_BEQ, 5'd0, 32'd5, 32'd5);
    #1;
    chk("beq_c1_branch", 32'(bus.branchD), 32'd1);
    chk("beq_c1_taken", 32'(bus.takenD), 32'd1);
    chk("beq_c1_mispred", 32'(bus.mispredictD), 32'd1);
    chk("same_idx_pred_now", 32'(bus.pred_takenF), 32'd0);
    tick();
    chk_cnt("beq_c1", 1, 1);
    chk("same_idx_pred_next", 32'(bus.pred_takenF), 32'd1);
    drive(1'b0, OP_BEQ, 5'd0, 32'd5, 32'd5);
    tick();
    drive(1'b1, OP_BEQ, 5'd0, 32'd5, 32'd5);
    #1 chk("beq_c3_mispred", 32'(bus.mispredictD), 32'd0);
    tick();
    chk_cnt("beq_c3", 2, 1);
    drive(1'b0, OP_BEQ, 5'd0, 32'd5, 32'd6);
    tick();
    // entry is 11: two not-taken resolutions take it 11->10->01
    drive(1'b1, OP_BEQ, 5'd0, 32'd5, 32'd6);
    #1;
    chk("beq_nt_taken", 32'(bus.takenD), 32'd0);
    chk("beq_nt_mispred", 32'(bus.mispredictD), 32'd1);
    tick();
    chk_cnt("beq_nt1", 3, 2);
    chk("sat_hi_pred", 32'(bus.pred_takenF), 32'd1);
    #1 chk("beq_nt2_mispred", 32'(bus.mispredictD), 32'd1);
    tick();
    chk_cnt("beq_nt2", 4, 3);
    chk("dec_pred", 32'(bus.pred_takenF), 32'd0);

    // ---- Decode table, validD low ----
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("dec%0d_branch", i), 32'(bus.branchD), 32'(vecs[i].eb));
      chk($sformatf("dec%0d_taken", i), 32'(bus.takenD), 32'(vecs[i].et));
      chk($sformatf("dec%0d_mispred", i), 32'(bus.mispredictD), 32'd0);
    end
    // Non-branch REGIMM subtype with validD high: no update
    drive(1'b1, OP_REGIMM, 5'b00010, 32'd0, 32'd0);
    tick();
    chk_cnt("regimm_nb", 4, 3);
    drive(1'b0, OP_R, 5'd0, 32'd0, 32'd0);

    // ---- Stall / flush ----
    do_reset();
    chk_cnt("rst2", 0, 0);
    bus.pcF = 32'h108;
    tick();
    drive(1'b1, OP_BEQ, 5'd0, 32'd7, 32'd7);
    #1 chk("stall_pre_mispred", 32'(bus.mispredictD), 32'd1);
    tick();
    drive(1'b0, OP_BEQ, 5'd0, 32'd7, 32'd7);
    #1 chk("stall_pre_pred", 32'(bus.pred_takenF), 32'd1);
    tick();
    bus.stallD = 1'b1;
    bus.pcF    = 32'h200;
    drive(1'b1, OP_BEQ, 5'd0, 32'd7, 32'd7);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_mispred", c), 32'(bus.mispredictD), 32'd0);
      tick();
      chk_cnt($sformatf("stall%0d", c), 1, 1);
    end
    bus.stallD = 1'b0;
    #1 chk("unstall_mispred", 32'(bus.mispredictD), 32'd0);
    tick();
    chk_cnt("unstall", 2, 1);
    bus.pcF    = 32'h108;
    bus.flushD = 1'b1;
    drive(1'b0, OP_BEQ, 5'd0, 32'd7, 32'd7);
    #1 chk("flush_pre_pred", 32'(bus.pred_takenF), 32'd1);
    tick();
    bus.flushD = 1'b0;
    bus.stallD = 1'b1;
    drive(1'b1, OP_BEQ, 5'd0, 32'd7, 32'd7);
    #1 chk("flush_mispred", 32'(bus.mispredictD), 32'd1);
    tick();
    chk_cnt("flush_stall", 2, 1);
    bus.stallD = 1'b0;
    tick();
    chk_cnt("flush_resolve", 3, 2);

    // ---- Counter saturation with distinct untrained indices ----
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      bus.pcF = 32'(4 * k);
      drive(1'b1, OP_BEQ, 5'd0, 32'd1, 32'd1);
      #1 chk($sformatf("sat%0d_mispred", k), 32'(bus.mispredictD), 32'd1);
      tick();
      chk_cnt($sformatf("sat%0d", k), (k > 15) ? 15 : k, (k > 15) ? 15 : k);
    end

    // ---- Asynchronous reset mid-stream ----
    bus.pcF = 32'h4;
    drive(1'b0, OP_BEQ, 5'd0, 32'd1, 32'd1);
    #1 chk("ar_pre_pred", 32'(bus.pred_takenF), 32'd1);
    tick();
    drive(1'b1, OP_BEQ, 5'd0, 32'd1, 32'd1);
    #1 chk("ar_pre_mispred", 32'(bus.mispredictD), 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("ar_pred", 32'(bus.pred_takenF), 32'd0);
    chk("ar_mispred", 32'(bus.mispredictD), 32'd1);
    chk("ar_taken", 32'(bus.takenD), 32'd1);
    chk_cnt("ar", 0, 0);
    tick();
    chk_cnt("ar_hold", 0, 0);
    resetn = 1'b1;
    #1 chk("ar_rel_pred", 32'(bus.pred_takenF), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch resolution unit for the five-stage MIPS pipeline. It evaluates every conditional branch (BEQ, BNE, BGTZ, BLEZ, BGEZ, BLTZ, BGEZAL, BLTZAL) in the decode stage, over a configurable operand width. It adds a 2-bit saturating branch-history table (BHT) that predicts in fetch and trains at resolution. It reports mispredictions to the hazard unit and keeps saturating performance counters.

## Interface
- DATA_W, 32: operand width for the compare.
- BHT_DEPTH, 64: number of BHT entries; must be a power of two, at least 2.
- IDX_W, $clog2(BHT_DEPTH): BHT index width (derived).
- CNT_W, 32: width of each performance counter.
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- pcF  in  32  fetch PC; BHT index is pcF[IDX_W+1:2].
- pred_takenF  out  1  combinational prediction for pcF: MSB of the indexed counter.
- stallD  in  1  holds the F→D prediction register.
- flushD  in  1  clears the F→D prediction register.
- validD  in  1  decode-stage instruction is valid.
- opD  in  6  opcode in decode.
- rtD  in  5  rt field; selects the REGIMM subtype.
- aD, bD  in  DATA_W  forwarded rs and rt values.
- branchD  out  1  opD/rtD decode to a conditional branch (combinational).
- takenD  out  1  resolved branch outcome (combinational).
- mispredictD  out  1  validD & branchD & (takenD != registered prediction).
- branch_cnt  out  CNT_W  count of retired resolutions.
- mispred_cnt  out  CNT_W  count of mispredictions.

## Operation
- Opcode decode:
  - BEQ 000100: a==b.
  - BNE 000101: a!=b.
  - BLEZ 000110: a[MSB]==1 or a==0.
  - BGTZ 000111: a[MSB]==0 and a!=0.
  - REGIMM 000001, rt 00001 BGEZ or 10001 BGEZAL: a[MSB]==0.
  - REGIMM 000001, rt 00000 BLTZ or 10000 BLTZAL: a[MSB]==1.
  - All other opD/rtD combinations: branchD=0, takenD=0.
- Sign tests use bit DATA_W-1.
- BHT entries are 2-bit counters:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Prediction is the counter MSB.
- F→D register holds predD and idxD (pcF[IDX_W+1:2]):
  - Loads each edge when stallD=0.
  - flushD=1 has priority over the load and clears predD=0, idxD=0.
  - stallD=1 with flushD=0 holds both fields.
- Resolution fires on an edge where validD=1, branchD=1 and stallD=0:
  - BHT[idxD] increments if takenD=1 (saturates at 11), else decrements (saturates at 00).
  - branch_cnt increments, saturating at all-ones.
  - mispred_cnt increments if mispredictD=1, saturating at all-ones.
- While stallD=1: no BHT update and no counter update; mispredictD still reflects current inputs.
- Same-index read and write in one cycle: pred_takenF returns the pre-update value. No bypass.

## Timing
- pred_takenF, branchD, takenD and mispredictD are combinational, with zero-cycle latency.
- BHT write and counter increments become visible on the edge after the resolution cycle.
- A prediction looked up in cycle N is compared in cycle N+1, or later if stallD is held.
- On resetn low, asynchronously and at any time including mid-update:
  - All BHT entries go to 01.
  - predD=0, idxD=0.
  - branch_cnt=0, mispred_cnt=0.
  - Consequently pred_takenF=0 and mispredictD=takenD for a valid branch.
- On resetn release, normal operation starts at the first rising edge.
- Throughput: one resolution per cycle.

## Test plan
- Reset, then a BEQ with aD=bD=5 and validD=1 resolved twice at the same PC:
  - Cycle 1: takenD=1, mispredictD=1.
  - BHT entry goes 01→10→11.
  - branch_cnt=2, mispred_cnt=1.
- BGTZ with aD=0x80000000 and with aD=0; BLEZ with aD=0:
  - BGTZ takenD=0 for both values.
  - BLEZ takenD=1.
- REGIMM with rtD=10001 (BGEZAL), aD=0 → takenD=1. REGIMM with rtD=00010 → branchD=0, no update.
- stallD held 3 cycles during a valid branch:
  - Counters unchanged until stallD falls, then +1 once.
  - predD is held through the stall.
- Lookup and update at the same index in one cycle with entry=01 and taken → pred_takenF=0 that cycle, 1 the next.
- mispred_cnt preloaded near saturation by driving repeated mispredictions with CNT_W=4 → holds at 15.
- resetn asserted mid-stream → all outputs return to the reset values immediately, without waiting for clk.
